// File: rtl/qformat_pkg.sv
// Shared Q-format helpers: sign-magnitude field access, iteration count and the
// state encoding used by the iterative Q-format units.
package qformat_pkg;

   typedef enum logic [1:0] {StIdle, StCalc, StDone} qstate_e;

   // Helpers take words of up to 64 bits, zero-extended by the caller; n is the real width.
   function automatic logic sm_sign(input logic [63:0] x, input int unsigned n);
      return x[6'(n - 1)];
   endfunction

   function automatic logic [63:0] sm_mag(input logic [63:0] x, input int unsigned n);
      return x & ((64'd1 << (n - 1)) - 64'd1);
   endfunction

   function automatic int unsigned qdiv_iter_len(input int unsigned n, input int unsigned q);
      return n - 1 + q;
   endfunction

endpackage

// File: rtl/qdiv_iter_step.sv
// One radix-2 restoring division step: shift a numerator bit into the remainder and
// subtract the divisor when it fits.
module qdiv_iter_step #(
   parameter int unsigned W = 31
) (
   input  logic [W-1:0] rem_i,
   input  logic [W-1:0] dvs_i,
   input  logic         bit_i,
   output logic [W-1:0] rem_o,
   output logic         qbit_o
);

   logic [W:0]   shifted;
   logic [W-1:0] diff;

   assign shifted = {rem_i, bit_i};
   // rem_i < dvs_i keeps shifted - dvs_i below 2^W, so the low W bits are exact.
   assign diff    = shifted[W-1:0] - dvs_i;
   assign qbit_o  = shifted >= {1'b0, dvs_i};
   assign rem_o   = qbit_o ? diff : shifted[W-1:0];

endmodule

// File: rtl/qdiv_iter.sv
// Sequential sign-magnitude Q-format divider: one quotient bit per clock, with
// saturation, divide-by-zero detection and a result held until the next start.
module qdiv_iter
   import qformat_pkg::*;
#(
   parameter int unsigned Q = 15,
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] quotient,
   output logic         busy,
   output logic         done,
   output logic         overflow,
   output logic         div_by_zero
);

   localparam int unsigned Iter = qdiv_iter_len(N, Q);
   localparam int unsigned MagW = N - 1;
   localparam int unsigned CntW = $clog2(Iter);

   qstate_e           state_q, state_d;
   logic [Iter-1:0]   num_q, num_d;
   logic [Iter-1:0]   quo_q, quo_d;
   logic [MagW-1:0]   rem_q, rem_d;
   logic [MagW-1:0]   dvs_q, dvs_d;
   logic              sign_q, sign_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]      quotient_q, quotient_d;
   logic              ovf_q, ovf_d;
   logic              dbz_q, dbz_d;

   logic [MagW-1:0]   dvd_mag, dvs_mag;
   logic              in_sign;
   logic [MagW-1:0]   step_rem;
   logic              step_qbit;
   logic [Iter-1:0]   final_quo;
   logic              sat;
   logic [MagW-1:0]   final_mag;

   assign dvd_mag = MagW'(sm_mag(64'(dividend), N));
   assign dvs_mag = MagW'(sm_mag(64'(divisor), N));
   assign in_sign = sm_sign(64'(dividend), N) ^ sm_sign(64'(divisor), N);

   qdiv_iter_step #(
      .W(MagW)
   ) u_step (
      .rem_i (rem_q),
      .dvs_i (dvs_q),
      .bit_i (num_q[Iter-1]),
      .rem_o (step_rem),
      .qbit_o(step_qbit)
   );

   assign final_quo = {quo_q[Iter-2:0], step_qbit};
   assign sat       = |final_quo[Iter-1:MagW];
   assign final_mag = sat ? {MagW{1'b1}} : final_quo[MagW-1:0];

   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvs_d      = dvs_q;
      sign_d     = sign_q;
      cnt_d      = cnt_q;
      quotient_d = quotient_q;
      ovf_d      = ovf_q;
      dbz_d      = dbz_q;
      case (state_q)
         StIdle, StDone: begin
            if (start) begin
               dvs_d  = dvs_mag;
               sign_d = in_sign;
               ovf_d  = 1'b0;
               dbz_d  = 1'b0;
               if (dvs_mag == '0) begin
                  state_d    = StDone;
                  quotient_d = {in_sign, {MagW{1'b1}}};
                  ovf_d      = 1'b1;
                  dbz_d      = 1'b1;
               end else begin
                  state_d = StCalc;
                  cnt_d   = CntW'(Iter - 1);
                  rem_d   = '0;
                  quo_d   = '0;
                  num_d   = {dvd_mag, {Q{1'b0}}};
               end
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StCalc: begin
            rem_d = step_rem;
            num_d = num_q << 1;
            quo_d = final_quo;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d    = StDone;
               // A zero magnitude never carries a negative sign.
               quotient_d = {(final_mag != '0) & sign_q, final_mag};
               ovf_d      = sat;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         num_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvs_q      <= '0;
         sign_q     <= 1'b0;
         cnt_q      <= '0;
         quotient_q <= '0;
         ovf_q      <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvs_q      <= dvs_d;
         sign_q     <= sign_d;
         cnt_q      <= cnt_d;
         quotient_q <= quotient_d;
         ovf_q      <= ovf_d;
         dbz_q      <= dbz_d;
      end
   end

   assign quotient    = quotient_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state_q == StCalc);
   assign done        = (state_q == StDone);

endmodule
